// File: rtl/mdio_arbiter_if.sv
// Requester and frame-engine signal bundle for mdio_arbiter.
// slave = arbiter side, master = requesters plus engine side.
interface mdio_arbiter_if #(
   parameter int N_REQ = 3
);
   logic [N_REQ-1:0]    req;
   logic [32*N_REQ-1:0] frame;
   logic [N_REQ-1:0]    gnt;
   logic [N_REQ-1:0]    done;
   logic                err;
   logic [15:0]         rdata;
   logic                busy;
   logic                eng_start;
   logic [31:0]         eng_wdata;
   logic [15:0]         eng_rdata;
   logic                eng_rd_done;
   logic                eng_wr_done;

   modport slave (
      input  req, frame, eng_rdata, eng_rd_done, eng_wr_done,
      output gnt, done, err, rdata, busy, eng_start, eng_wdata
   );

   modport master (
      output req, frame, eng_rdata, eng_rd_done, eng_wr_done,
      input  gnt, done, err, rdata, busy, eng_start, eng_wdata
   );
endinterface

// File: rtl/mdio_arbiter.sv
// Round-robin arbiter sharing one MDIO frame engine among N_REQ requesters;
// runs the engine strobe/wait handshake per frame with a timeout abort.
module mdio_arbiter #(
   parameter int N_REQ   = 3,
   parameter int TIMEOUT = 100000
) (
   input logic          clk,
   input logic          rst,
   mdio_arbiter_if.slave bus
);
   localparam int          LW   = $clog2(N_REQ);
   localparam int unsigned NR   = N_REQ;
   localparam logic [23:0] TMAX = 24'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_STRB, S_WAIT, S_DONE} state_t;

   state_t            state, state_d;
   logic [N_REQ-1:0]  gnt_q, gnt_d, done_q, done_d;
   logic              err_q, err_d, start_q, start_d;
   logic [15:0]       rdata_q, rdata_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [LW-1:0]     last_q, last_d;
   logic [1:0]        op_q, op_d;
   logic [23:0]       timer_q, timer_d;

   logic [31:0]       frames [N_REQ];
   logic              found;
   logic [LW-1:0]     win, cand;
   logic [N_REQ-1:0]  win_oh;
   logic [31:0]       win_frame;
   logic              sel_done, timed_out;
   int unsigned       idx;

   for (genvar g = 0; g < N_REQ; g++) begin : g_frame
      assign frames[g] = bus.frame[32*g +: 32];
   end

   // Scan last+1, last+2, ... wrapping at N_REQ; first set request wins.
   always_comb begin
      found = 1'b0;
      win   = last_q;
      idx   = 0;
      cand  = '0;
      for (int unsigned k = 1; k <= NR; k++) begin
         idx = 32'(last_q) + k;
         if (idx >= NR) idx = idx - NR;
         cand = LW'(idx);
         if (!found && bus.req[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
      win_oh      = '0;
      win_oh[win] = 1'b1;
      win_frame   = frames[win];
   end

   assign sel_done  = (op_q == 2'b10) ? bus.eng_rd_done : bus.eng_wr_done;
   assign timed_out = (timer_q >= TMAX);

   always_comb begin
      state_d = state;
      gnt_d   = gnt_q;
      done_d  = '0;
      err_d   = err_q;
      start_d = start_q;
      rdata_d = rdata_q;
      wdata_d = wdata_q;
      last_d  = last_q;
      op_d    = op_q;
      timer_d = timer_q;
      unique case (state)
         S_IDLE: begin
            if (found) begin
               gnt_d   = win_oh;
               last_d  = win;
               wdata_d = win_frame;
               op_d    = win_frame[29:28];
               timer_d = '0;
               if (win_frame[29:28] == 2'b10 || win_frame[29:28] == 2'b01) begin
                  start_d = 1'b1;
                  state_d = S_STRB;
               end else begin
                  err_d   = 1'b1;
                  done_d  = win_oh;
                  state_d = S_DONE;
               end
            end
         end
         S_STRB: begin
            timer_d = timer_q + 24'd1;
            if (!sel_done) begin
               start_d = 1'b0;
               state_d = S_WAIT;
            end else if (timed_out) begin
               start_d = 1'b0;
               err_d   = 1'b1;
               done_d  = gnt_q;
               state_d = S_DONE;
            end
         end
         S_WAIT: begin
            timer_d = timer_q + 24'd1;
            // Completion is checked first so it wins over a same-cycle timeout.
            if (sel_done) begin
               if (op_q == 2'b10) rdata_d = bus.eng_rdata;
               err_d   = 1'b0;
               done_d  = gnt_q;
               state_d = S_DONE;
            end else if (timed_out) begin
               err_d   = 1'b1;
               done_d  = gnt_q;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            gnt_d   = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         gnt_q   <= '0;
         done_q  <= '0;
         err_q   <= 1'b0;
         start_q <= 1'b0;
         rdata_q <= '0;
         wdata_q <= '0;
         last_q  <= LW'(N_REQ - 1);
         op_q    <= '0;
         timer_q <= '0;
      end else begin
         state   <= state_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         err_q   <= err_d;
         start_q <= start_d;
         rdata_q <= rdata_d;
         wdata_q <= wdata_d;
         last_q  <= last_d;
         op_q    <= op_d;
         timer_q <= timer_d;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign bus.rdata     = rdata_q;
   assign bus.busy      = (state != S_IDLE);
   assign bus.eng_start = start_q;
   assign bus.eng_wdata = wdata_q;
endmodule

// File: tb/tb_mdio_arbiter.sv
// Randomized bench for mdio_arbiter: drives requesters and a behavioural
// frame engine, checking against a transaction-level arbitration model.
module tb_mdio_arbiter;
   localparam int N  = 3;
   localparam int TO = 50;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mdio_arbiter_if #(.N_REQ(N)) bus ();

   mdio_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Engine behaviour knobs: drop delay, frame time, mode (0 normal,
   // 1 hang after drop, 2 never drop), read value returned.
   int          eng_d = 0, eng_f = 0, eng_mode = 0;
   logic [15:0] eng_val = '0;

   logic [N-1:0] pend;
   logic [31:0]  frm [N];
   int           m_last;
   logic [15:0]  m_rdata;
   logic         m_err;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive();
      logic [32*N-1:0] fv;
      fv = '0;
      for (int i = 0; i < N; i++) fv = fv | ((32*N)'(frm[i]) << (32*i));
      bus.req   = pend;
      bus.frame = fv;
   endtask

   function automatic int pick(input logic [N-1:0] r, input int last);
      logic [N-1:0] t;
      for (int k = 1; k <= N; k++) begin
         t = r >> ((last + k) % N);
         if (t[0]) return (last + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [31:0] rand_frame();
      logic [31:0] r;
      int          c;
      r = $urandom;
      c = $urandom_range(0, 19);
      r[31:30] = 2'b01;
      r[17:16] = 2'b10;
      if (c < 9)       r[29:28] = 2'b10;
      else if (c < 18) r[29:28] = 2'b01;
      else if (c < 19) r[29:28] = 2'b11;
      else             r[29:28] = 2'b00;
      return r;
   endfunction

   // Behavioural frame engine: drops the done level of the path matching
   // the frame opcode, then raises it after the frame time.
   initial begin
      int   phase;
      int   cnt;
      logic rd_path;
      phase = 0;
      cnt = 0;
      rd_path = 1'b0;
      bus.eng_rd_done = 1'b1;
      bus.eng_wr_done = 1'b1;
      bus.eng_rdata   = '0;
      forever begin
         tick();
         if (rst || (phase != 0 && !bus.busy)) begin
            phase = 0;
            bus.eng_rd_done = 1'b1;
            bus.eng_wr_done = 1'b1;
         end else begin
            if (phase == 0 && bus.eng_start) begin
               phase   = 1;
               cnt     = eng_d;
               rd_path = (bus.eng_wdata[29:28] == 2'b10);
            end
            if (phase == 1) begin
               if (eng_mode != 2) begin
                  if (cnt == 0) begin
                     if (rd_path) bus.eng_rd_done = 1'b0;
                     else         bus.eng_wr_done = 1'b0;
                     phase = 2;
                     cnt   = eng_f;
                  end else cnt--;
               end
            end else if (phase == 2) begin
               if (eng_mode != 1) begin
                  if (cnt == 0) begin
                     bus.eng_rdata = eng_val;
                     if (rd_path) bus.eng_rd_done = 1'b1;
                     else         bus.eng_wr_done = 1'b1;
                     phase = 0;
                  end else cnt--;
               end
            end
         end
      end
   end

   // One full transaction from IDLE: grant, handshake, done, back to IDLE.
   task automatic do_txn(input int d, input int f, input int mode, input logic [15:0] val);
      int          w, k_done, k_exit;
      logic [31:0] fr;
      logic        valid, isrd;
      eng_d = d; eng_f = f; eng_mode = mode; eng_val = val;
      drive();
      w     = pick(pend, m_last);
      fr    = frm[w];
      valid = (fr[29:28] == 2'b10) || (fr[29:28] == 2'b01);
      isrd  = (fr[29:28] == 2'b10);
      if (!valid) begin
         k_done = 0; k_exit = 0;
      end else if (mode == 0) begin
         k_done = 2 + d + f; k_exit = 1 + d;
      end else begin
         k_done = TO; k_exit = (mode == 2) ? TO : 1 + d;
      end
      tick();
      m_last = w;
      for (int k = 0; k <= k_done; k++) begin
         if (k > 0) tick();
         if (k == 1 && $urandom_range(0, 3) == 0) begin
            pend[w] = 1'b0;
            frm[w]  = $urandom;
            drive();
         end
         check_eq("gnt", bus.gnt, 32'(1) << w);
         check_eq("eng_start", bus.eng_start, k < k_exit);
         check_eq("busy", bus.busy, 1);
         if (k == 0) check_eq("eng_wdata", bus.eng_wdata, fr);
         check_eq("done", bus.done, (k == k_done) ? (32'(1) << w) : 0);
      end
      if (!valid || mode != 0) m_err = 1'b1;
      else begin
         m_err = 1'b0;
         if (isrd) m_rdata = val;
      end
      check_eq("err", bus.err, m_err);
      check_eq("rdata", bus.rdata, m_rdata);
      pend[w] = 1'b0;
      drive();
      tick();
      check_eq("idle_gnt", bus.gnt, 0);
      check_eq("idle_done", bus.done, 0);
      check_eq("idle_busy", bus.busy, 0);
      check_eq("err_hold", bus.err, m_err);
   endtask

   initial begin
      rst  = 1'b1;
      pend = '0;
      for (int i = 0; i < N; i++) frm[i] = '0;
      drive();
      tick();
      tick();
      check_eq("rst_gnt", bus.gnt, 0);
      check_eq("rst_done", bus.done, 0);
      check_eq("rst_err", bus.err, 0);
      check_eq("rst_rdata", bus.rdata, 0);
      check_eq("rst_busy", bus.busy, 0);
      check_eq("rst_start", bus.eng_start, 0);
      check_eq("rst_wdata", bus.eng_wdata, 0);
      rst = 1'b0;
      tick();
      m_last = N - 1; m_rdata = '0; m_err = 1'b0;

      // Round robin with all three held, then 101 after last=2.
      pend = 3'b111;
      for (int i = 0; i < N; i++) frm[i] = {2'b01, 2'b10, 5'(i), 5'd1, 2'b10, 16'h0};
      for (int i = 0; i < N; i++) do_txn(i, 1, 0, 16'h1000 + 16'(i));
      pend = 3'b101;
      do_txn(0, 0, 0, 16'h2000);
      do_txn(1, 0, 0, 16'h2002);

      // Single read, write, bad opcode.
      pend = 3'b010; frm[1] = 32'h6188_0000;
      do_txn(1, 2, 0, 16'hAC00);
      pend = 3'b001; frm[0] = {2'b01, 2'b01, 5'd1, 5'd0, 2'b10, 16'h8140};
      do_txn(0, 3, 0, 16'h5555);
      pend = 3'b100; frm[2] = 32'h7000_0000;
      do_txn(0, 0, 0, 16'h0);

      // Timeouts (hang in WAIT, hang in STRB) then a normal transfer.
      pend = 3'b001; frm[0] = 32'h6188_0000;
      do_txn(1, 0, 1, 16'hDEAD);
      pend = 3'b010; frm[1] = 32'h5188_1234;
      do_txn(0, 0, 2, 16'hBEEF);
      pend = 3'b100; frm[2] = 32'h6208_0000;
      do_txn(0, 1, 0, 16'h4321);

      // Randomized traffic.
      for (int t = 0; t < 150; t++) begin
         int c, mode;
         for (int i = 0; i < N; i++)
            if (!pend[i] && $urandom_range(0, 1) == 1) begin
               pend[i] = 1'b1;
               frm[i]  = rand_frame();
            end
         if (pend == '0) begin
            pend[0] = 1'b1;
            frm[0]  = rand_frame();
         end
         c    = $urandom_range(0, 19);
         mode = (c == 0) ? 1 : (c == 1) ? 2 : 0;
         do_txn($urandom_range(0, 3), $urandom_range(0, 6), mode, 16'($urandom));
      end

      // Reset in the middle of S_WAIT.
      pend = 3'b001; frm[0] = 32'h6188_0000;
      eng_d = 0; eng_f = 20; eng_mode = 0; eng_val = 16'h7777;
      drive();
      tick();
      check_eq("pre_rst_gnt", bus.gnt, 1);
      repeat (4) tick();
      check_eq("pre_rst_busy", bus.busy, 1);
      rst = 1'b1;
      #1;
      check_eq("rst_mid_gnt", bus.gnt, 0);
      check_eq("rst_mid_start", bus.eng_start, 0);
      check_eq("rst_mid_busy", bus.busy, 0);
      check_eq("rst_mid_done", bus.done, 0);
      tick();
      tick();
      rst  = 1'b0;
      pend = '0;
      drive();
      for (int k = 0; k < 25; k++) begin
         tick();
         check_eq("no_done_after_rst", bus.done, 0);
      end
      m_last = N - 1; m_rdata = '0; m_err = 1'b0;
      pend = 3'b101; frm[0] = 32'h5100_00AA; frm[2] = 32'h6100_0000;
      do_txn(0, 1, 0, 16'h3333);
      do_txn(0, 0, 0, 16'h4444);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
